// File: rtl/gcd_arbiter_if.sv
// -----------------------------------------------------------------------------
// gcd_arbiter_if
//
// Bundles the requester side and the engine side of gcd_arbiter into one
// interface. The arbiter connects through the slave modport. The environment
// (requesters plus the GCD engine, or a testbench) connects through the
// master modport.
//
// Requester side:
//   req      - per-requester request level
//   req_a    - flattened operand A, requester i at [i*W +: W]
//   req_b    - flattened operand B, same packing
//   done     - one-hot, one-cycle result-valid pulse
//   rsp_gcd  - result, nonzero only while done is nonzero
//   grant_id - index of the requester being (or last) served
//   busy     - arbiter is not idle
// Engine side:
//   eng_start, eng_ack, eng_cen - handshake and single-step enable
//   eng_ain, eng_bin            - operands driven to the engine
//   eng_done, eng_gcd           - engine done flag and result
//
// N_REQ and W must match the parameters of the gcd_arbiter instance.
// -----------------------------------------------------------------------------
interface gcd_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  localparam int IW = $clog2(N_REQ);

  // Requester side
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   done;
  logic [W-1:0]       rsp_gcd;
  logic [IW-1:0]      grant_id;
  logic               busy;

  // Engine side
  logic               eng_start;
  logic               eng_ack;
  logic               eng_cen;
  logic [W-1:0]       eng_ain;
  logic [W-1:0]       eng_bin;
  logic               eng_done;
  logic [W-1:0]       eng_gcd;

  // Arbiter view
  modport slave (
    input  req, req_a, req_b, eng_done, eng_gcd,
    output done, rsp_gcd, grant_id, busy,
    output eng_start, eng_ack, eng_cen, eng_ain, eng_bin
  );

  // Environment view: requesters and the engine
  modport master (
    output req, req_a, req_b, eng_done, eng_gcd,
    input  done, rsp_gcd, grant_id, busy,
    input  eng_start, eng_ack, eng_cen, eng_ain, eng_bin
  );
endinterface

// File: rtl/gcd_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_arbiter
//
// Round-robin arbiter that shares one GCD engine among N_REQ requesters.
// In IDLE it picks the next requesting index after the last one served and
// latches that requester's operands. It then either runs the engine
// Start/Done/Ack handshake, or returns the answer directly when an operand is
// zero, because the engine never terminates on a zero operand. The result
// comes back as a one-cycle one-hot done pulse together with rsp_gcd.
//
// Ports:
//   Clk   - system clock, all state on the rising edge
//   Reset - synchronous active-high reset (the same net resets the engine)
//   CEN   - engine single-step enable, passed straight through to eng_cen
//   bus   - gcd_arbiter_if.slave: requester bus and engine handshake
//
// Job timeline (T0 = IDLE cycle that grants):
//   engine job : LAUNCH at T0+1, WAIT until eng_done is seen in cycle Td,
//                ACK (done + eng_ack) at Td+1, IDLE at Td+2
//   bypass job : BYPASS (done) at T0+1, IDLE at T0+2
// -----------------------------------------------------------------------------
module gcd_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           CEN,
  gcd_arbiter_if.slave   bus
);

  localparam int            IW         = $clog2(N_REQ);
  // Pointer value that gives requester 0 first priority after reset.
  localparam logic [IW-1:0] LAST_RESET = IW'(N_REQ - 1);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LAUNCH = 5'b00010,
    S_WAIT   = 5'b00100,
    S_ACK    = 5'b01000,
    S_BYPASS = 5'b10000
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [IW-1:0] last_q;     // last requester granted
  logic [IW-1:0] grant_q;    // requester currently being served
  logic [W-1:0]  a_q;        // latched operand A
  logic [W-1:0]  b_q;        // latched operand B
  logic [W-1:0]  result_q;   // engine result or bypass answer

  // Round-robin search results
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [W-1:0]  hit_a;
  logic [W-1:0]  hit_b;
  logic          hit_zero;

  logic          grant_now;
  logic          capture_now;
  logic          engaged;

  // ---------------------------------------------------------------------------
  // Round-robin search starting at last_q+1 and wrapping. The loop runs from
  // the farthest candidate down to the nearest, so the nearest requesting
  // index is the one written last and wins.
  // ---------------------------------------------------------------------------
  always_comb begin : rr_search
    logic [IW-1:0] cand;
    hit     = 1'b0;
    hit_idx = last_q;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % N_REQ);
      if (bus.req[cand]) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
    hit_a    = bus.req_a[hit_idx*W +: W];
    hit_b    = bus.req_b[hit_idx*W +: W];
    hit_zero = (hit_a == '0) || (hit_b == '0);
  end

  assign grant_now   = (state == S_IDLE) && hit;
  assign capture_now = (state == S_WAIT) && bus.eng_done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // Grant pointer, operand and result registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand and result registers are reset as well, not just the
  // control state, because they drive eng_ain/eng_bin/grant_id directly and
  // every output must read 0 after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q   <= LAST_RESET;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      if (grant_now) begin
        last_q  <= hit_idx;
        grant_q <= hit_idx;
        a_q     <= hit_a;
        b_q     <= hit_b;
        // Bypass answer: the nonzero operand, or 0 when both are zero.
        // For engine jobs the value is overwritten when eng_done arrives.
        result_q <= (hit_a == '0) ? hit_b : hit_a;
      end
      if (capture_now) begin
        result_q <= bus.eng_gcd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  assign engaged = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_ACK);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx      = state;
    bus.done      = '0;
    bus.rsp_gcd   = '0;
    bus.busy      = (state != S_IDLE);
    bus.grant_id  = grant_q;
    bus.eng_start = 1'b0;
    bus.eng_ack   = 1'b0;
    // Operands are shown to the engine only while it owns the job.
    bus.eng_ain   = engaged ? a_q : '0;
    bus.eng_bin   = engaged ? b_q : '0;

    case (state)
      S_IDLE: begin
        if (hit) state_nx = hit_zero ? S_BYPASS : S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.eng_start = 1'b1;
        state_nx      = S_WAIT;
      end
      S_WAIT: begin
        // CEN only slows the engine; the arbiter simply keeps waiting.
        if (bus.eng_done) state_nx = S_ACK;
      end
      S_ACK: begin
        bus.eng_ack            = 1'b1;
        bus.done[grant_q]      = 1'b1;
        bus.rsp_gcd            = result_q;
        state_nx               = S_IDLE;
      end
      S_BYPASS: begin
        bus.done[grant_q]      = 1'b1;
        bus.rsp_gcd            = result_q;
        state_nx               = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.eng_cen = CEN;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_state_onehot: assert property (@(posedge Clk) disable iff (Reset)
    $onehot(state));

  a_done_onehot0: assert property (@(posedge Clk) disable iff (Reset)
    $onehot0(bus.done));

  a_rsp_quiet: assert property (@(posedge Clk) disable iff (Reset)
    (bus.done == '0) |-> (bus.rsp_gcd == '0));

  a_start_single: assert property (@(posedge Clk) disable iff (Reset)
    bus.eng_start |=> !bus.eng_start);

endmodule

// File: tb/tb_gcd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gcd_arbiter
//
// Drives gcd_arbiter with directed jobs and a small subtract-based GCD engine.
// A job-level reference model predicts every output in every cycle: which
// requester wins, when done/eng_start/eng_ack appear and what the result is.
// A handful of literal expectations then pin grant order, results and latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gcd_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b1;
  int   cen_mode = 0;   // 0: CEN high, 1: high one cycle in four, 2: low

  always #5 clk = ~clk;

  gcd_arbiter_if #(.N_REQ(N), .W(W)) bus();

  gcd_arbiter #(.N_REQ(N), .W(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .CEN   (cen),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: actual %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural GCD engine: latches operands on eng_start, subtracts once per
  // eng_cen cycle, then holds eng_done until eng_ack.
  // ---------------------------------------------------------------------------
  logic [W-1:0] ex, ey;
  logic         e_run;

  always @(posedge clk) begin
    if (rst) begin
      e_run        <= 1'b0;
      ex           <= '0;
      ey           <= '0;
      bus.eng_done <= 1'b0;
      bus.eng_gcd  <= '0;
    end else if (bus.eng_done) begin
      if (bus.eng_ack) bus.eng_done <= 1'b0;
    end else if (e_run) begin
      if (bus.eng_cen) begin
        if (ex == ey) begin
          e_run        <= 1'b0;
          bus.eng_done <= 1'b1;
          bus.eng_gcd  <= ex;
        end else if (ex > ey) begin
          ex <= ex - ey;
        end else begin
          ey <= ey - ex;
        end
      end
    end else if (bus.eng_start) begin
      ex    <= bus.eng_ain;
      ey    <= bus.eng_bin;
      e_run <= 1'b1;
    end
  end

  // CEN pattern generator
  initial forever begin
    @(posedge clk);
    #1;
    case (cen_mode)
      1:       cen = (cyc % 4 == 0);
      2:       cen = 1'b0;
      default: cen = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Job currently owned by the arbiter, in job terms.
  bit            job_valid = 0;
  logic [IW-1:0] job_id    = '0;
  logic [W-1:0]  job_a     = '0;
  logic [W-1:0]  job_b     = '0;
  bit            job_bypass = 0;
  bit            job_ack   = 0;
  int            job_age   = 0;
  int            ptr       = N - 1;

  // Expected outputs for the current cycle
  logic [N-1:0]  exp_done  = '0;
  logic [W-1:0]  exp_rsp   = '0;
  logic          exp_start = 1'b0;
  logic          exp_ack   = 1'b0;
  logic          exp_busy  = 1'b0;
  logic [IW-1:0] exp_gid   = '0;
  logic [W-1:0]  exp_ain   = '0;
  logic [W-1:0]  exp_bin   = '0;

  // Observation log for the literal expectations
  int done_id_q[$];
  int done_rsp_q[$];
  int done_cyc_q[$];
  int start_count = 0;
  int ack_count   = 0;

  task automatic model_step();
    logic [N-1:0] nd;
    logic [W-1:0] nr, na, nb;
    logic         ns, nk, nbusy;
    int           hit, c;
    nd = '0; nr = '0; na = '0; nb = '0; ns = 1'b0; nk = 1'b0; nbusy = 1'b0;
    if (rst) begin
      job_valid = 0;
      ptr       = N - 1;
      exp_gid   = '0;
    end else if (!job_valid) begin
      hit = -1;
      for (int k = 1; k <= N; k++) begin
        c = (ptr + k) % N;
        if (hit < 0 && (bus.req & (N'(1) << c)) != '0) hit = c;
      end
      if (hit >= 0) begin
        job_valid  = 1;
        job_id     = IW'(hit);
        job_a      = op_a[hit];
        job_b      = op_b[hit];
        job_bypass = (job_a == 0) || (job_b == 0);
        job_ack    = 0;
        job_age    = 1;
        ptr        = hit;
        exp_gid    = job_id;
        nbusy      = 1'b1;
        if (job_bypass) begin
          nd = N'(1) << hit;
          nr = gcd_ref(job_a, job_b);
        end else begin
          ns = 1'b1;
          na = job_a;
          nb = job_b;
        end
      end
    end else if (job_bypass || job_ack) begin
      job_valid = 0;
    end else begin
      nbusy = 1'b1;
      na    = job_a;
      nb    = job_b;
      if (job_age > 1 && bus.eng_done) begin
        job_ack = 1;
        nk      = 1'b1;
        nd      = N'(1) << job_id;
        nr      = gcd_ref(job_a, job_b);
      end
      job_age++;
    end
    exp_done  = nd;
    exp_rsp   = nr;
    exp_start = ns;
    exp_ack   = nk;
    exp_busy  = nbusy;
    exp_ain   = na;
    exp_bin   = nb;
  endtask

  // Compare, log, then advance the model for the next cycle.
  initial forever begin
    @(negedge clk);
    if (cyc >= 1) begin
      check("done",      bus.done,      exp_done);
      check("rsp_gcd",   bus.rsp_gcd,   exp_rsp);
      check("eng_start", bus.eng_start, exp_start);
      check("eng_ack",   bus.eng_ack,   exp_ack);
      check("busy",      bus.busy,      exp_busy);
      check("grant_id",  bus.grant_id,  exp_gid);
      check("eng_ain",   bus.eng_ain,   exp_ain);
      check("eng_bin",   bus.eng_bin,   exp_bin);
      check("eng_cen",   bus.eng_cen,   cen);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.done == (N'(1) << i)) begin
        done_id_q.push_back(i);
        done_rsp_q.push_back(int'(bus.rsp_gcd));
        done_cyc_q.push_back(cyc);
      end
    end
    if (bus.eng_start) start_count++;
    if (bus.eng_ack)   ack_count++;
    model_step();
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  // Raise set_mask; requesters outside hold_mask drop after their done pulse.
  // Everything drops once n_dones pulses have been seen or the budget expires.
  task automatic serve(input logic [N-1:0] set_mask, input logic [N-1:0] hold_mask,
                       input int n_dones, input int budget);
    int seen;
    int c;
    seen = 0;
    c    = 0;
    bus.req = set_mask;
    while (seen < n_dones && c < budget) begin
      tick();
      c++;
      if (bus.done != '0) begin
        seen++;
        bus.req = bus.req & ~(bus.done & ~hold_mask);
      end
    end
    bus.req = '0;
    check("dones_seen", seen, n_dones);
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin : stim
    int mark, sc, ac, t0;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < N; i++) set_ops(i, 8'd0, 8'd0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_gid",  bus.grant_id, 0);

    // 1. Single job
    set_ops(0, 8'd36, 8'd24);
    mark = done_id_q.size();
    sc   = start_count;
    serve(4'b0001, 4'b0000, 1, 200);
    check("t1_id",     done_id_q[mark],  0);
    check("t1_rsp",    done_rsp_q[mark], 12);
    check("t1_starts", start_count - sc, 1);

    // 2. All four requesting from a fresh pointer
    pulse_reset();
    tick();
    set_ops(0, 8'd12, 8'd18);
    set_ops(1, 8'd35, 8'd14);
    set_ops(2, 8'd64, 8'd48);
    set_ops(3, 8'd17, 8'd5);
    mark = done_id_q.size();
    serve(4'b1111, 4'b0000, 4, 600);
    check("t2_id0",  done_id_q[mark+0],  0);
    check("t2_id1",  done_id_q[mark+1],  1);
    check("t2_id2",  done_id_q[mark+2],  2);
    check("t2_id3",  done_id_q[mark+3],  3);
    check("t2_rsp0", done_rsp_q[mark+0], 6);
    check("t2_rsp1", done_rsp_q[mark+1], 7);
    check("t2_rsp2", done_rsp_q[mark+2], 16);
    check("t2_rsp3", done_rsp_q[mark+3], 1);

    // 3. Fairness
    set_ops(0, 8'd30, 8'd12);
    set_ops(1, 8'd21, 8'd14);
    set_ops(2, 8'd8,  8'd20);
    mark = done_id_q.size();
    serve(4'b0010, 4'b0000, 1, 200);
    serve(4'b0101, 4'b0101, 4, 600);
    check("t3_first", done_id_q[mark+0], 1);
    check("t3_g0",    done_id_q[mark+1], 2);
    check("t3_g1",    done_id_q[mark+2], 0);
    check("t3_g2",    done_id_q[mark+3], 2);
    check("t3_g3",    done_id_q[mark+4], 0);
    check("t3_rsp2",  done_rsp_q[mark+1], 4);
    mark = done_id_q.size();
    serve(4'b0111, 4'b0111, 4, 600);
    check("t3_rr0", done_id_q[mark+0], 1);
    check("t3_rr1", done_id_q[mark+1], 2);
    check("t3_rr2", done_id_q[mark+2], 0);
    check("t3_rr3", done_id_q[mark+3], 1);

    // 4. Zero-operand bypass
    set_ops(3, 8'd0, 8'd15);
    mark = done_id_q.size();
    sc   = start_count;
    t0   = cyc;
    serve(4'b1000, 4'b0000, 1, 50);
    check("t4_id",      done_id_q[mark],  3);
    check("t4_rsp",     done_rsp_q[mark], 15);
    check("t4_latency", done_cyc_q[mark], t0 + 1);
    check("t4_nostart", start_count - sc, 0);
    set_ops(3, 8'd0, 8'd0);
    mark = done_id_q.size();
    serve(4'b1000, 4'b0000, 1, 50);
    check("t4_zero_rsp", done_rsp_q[mark], 0);
    set_ops(2, 8'd7, 8'd0);
    mark = done_id_q.size();
    serve(4'b0100, 4'b0000, 1, 50);
    check("t4_b_zero_rsp", done_rsp_q[mark], 7);
    check("t4_nostart_all", start_count - sc, 0);

    // 5. CEN stall at 1/4 duty
    set_ops(1, 8'd48, 8'd18);
    mark = done_id_q.size();
    sc   = start_count;
    ac   = ack_count;
    cen_mode = 1;
    serve(4'b0010, 4'b0000, 1, 600);
    cen_mode = 0;
    check("t5_rsp",    done_rsp_q[mark], 6);
    check("t5_starts", start_count - sc, 1);
    check("t5_acks",   ack_count - ac,   1);

    // 6. Reset in the middle of WAIT
    set_ops(1, 8'd100, 8'd75);
    mark = done_id_q.size();
    cen_mode = 2;
    bus.req = 4'b0010;
    repeat (4) tick();
    check("t6_busy_before", bus.busy, 1);
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    check("t6_busy",  bus.busy,     0);
    check("t6_done",  bus.done,     0);
    check("t6_gid",   bus.grant_id, 0);
    check("t6_ain",   bus.eng_ain,  0);
    check("t6_start", bus.eng_start, 0);
    cen_mode = 0;
    repeat (6) tick();
    check("t6_no_done", done_id_q.size(), mark);
    set_ops(2, 8'd9, 8'd6);
    serve(4'b0100, 4'b0000, 1, 200);
    check("t6_id",  done_id_q[mark],  2);
    check("t6_rsp", done_rsp_q[mark], 3);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter that shares one GCD engine among `N_REQ` requesters. It latches the winning requester's operands and runs the engine's Start/Done/Ack handshake. It returns the result to that requester with a one-cycle done pulse. Zero operands bypass the engine, because the engine does not terminate on them. The block sits between the top-level requesters (switch/button logic, game modules) and the GCD engine instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `W`, 8, operand and result width
- `Clk`  in  1  system clock; all logic on rising edge
- `Reset`  in  1  synchronous, active-high reset; the same net also resets the engine
- `CEN`  in  1  engine single-step enable; passed through to `eng_cen`; the arbiter itself never stalls
- `req`  in  N_REQ  per-requester request level
- `req_a`  in  N_REQ*W  flattened operand A; requester i occupies bits [i*W +: W]
- `req_b`  in  N_REQ*W  flattened operand B, same packing as `req_a`
- `done`  out  N_REQ  one-hot, one-cycle result-valid pulse
- `rsp_gcd`  out  W  result; valid only while `done` is nonzero
- `grant_id`  out  clog2(N_REQ)  index of the requester currently being served
- `busy`  out  1  high in every state except IDLE
- `eng_start`, `eng_ack`, `eng_cen`  out  1  engine handshake and enable
- `eng_ain`, `eng_bin`  out  W  operands driven to the engine
- `eng_done`  in  1  engine done-state flag
- `eng_gcd`  in  W  engine result

## Operation
- States, one-hot: IDLE, LAUNCH, WAIT, ACK, BYPASS.
- **Reset value:** state IDLE, every output 0, last-grant pointer = N_REQ-1, so requester 0 has first priority.
- **IDLE**
  - Search `req` starting at (last+1) mod N_REQ, wrapping around.
  - On a hit at index i: latch a_i and b_i into operand registers, set `grant_id` = i, set last = i.
  - If a_i == 0 or b_i == 0, go to BYPASS; otherwise go to LAUNCH.
  - With no request, stay in IDLE.
- **LAUNCH**
  - `eng_start` = 1 for exactly this one cycle.
  - `eng_ain` and `eng_bin` show the latched operands. They stay stable from LAUNCH through ACK.
  - Next state: WAIT.
- **WAIT**
  - Hold the operands and keep `eng_start` = 0.
  - When `eng_done` = 1, capture `eng_gcd` into the result register and go to ACK.
- **ACK**
  - `eng_ack` = 1.
  - `done[grant_id]` = 1 and `rsp_gcd` = captured result, both for this one cycle.
  - Next state: IDLE.
- **BYPASS**
  - `done[grant_id]` = 1 for one cycle.
  - `rsp_gcd` = the nonzero operand, or 0 if both operands are 0.
  - The engine is untouched.
  - Next state: IDLE.
- `eng_cen` = `CEN` combinationally.
- `rsp_gcd` is 0 whenever `done` is 0.

**Requester rules:**
- Hold `req` high until your `done` pulse; operands are sampled only in the IDLE grant cycle.
- If `req` drops mid-job, the job still completes and the `done` pulse is still issued.
- If `req` is still high after `done`, it is a new request. It is served again only after all other pending requesters, by round-robin order.

## Timing
- Grant decision: in the IDLE cycle where `req` is sampled (cycle T0).
- LAUNCH is cycle T0+1. The engine leaves its idle state at the end of T0+1.
- WAIT lasts until the first cycle in which `eng_done` is sampled high, cycle Td.
- The ACK pulse (`done` and `eng_ack`) is in cycle Td+1. IDLE resumes at Td+2.
- Back-to-back grants: the next grant can occur at Td+2, so the gap between grants is at most one idle cycle.
- Bypass latency: `done` in cycle T0+1; IDLE again at T0+2.
- `CEN` low only extends WAIT; no arbiter state or counter advances differently.
- Simultaneous requests:
  - Exactly one winner per grant cycle.
  - Losers are not sampled and are not acknowledged.
  - A new request arriving during a job is queued implicitly by its held `req` level.
- Reset asserted in any state:
  - The next state is IDLE with all outputs 0.
  - No `done` pulse is produced for the aborted job.
  - The pointer returns to N_REQ-1.
  - If a `done` pulse is due in the reset cycle, reset wins.

## Test plan
1. **Single job:** req[0]=1, a=36, b=24.
   - `eng_start` in T0+1; `done`=4'b0001 with `rsp_gcd`=12 one cycle after `eng_done` rises.
   - `eng_ack` is high in that same cycle; `busy` falls the cycle after.
2. **All four requesting** with (12,18), (35,14), (64,48), (17,5), held until served:
   - `done` order is 0,1,2,3; results are 6, 7, 16, 1.
   - `grant_id` matches each job; no overlap between jobs.
3. **Fairness:** serve requester 1, then hold req[0] and req[2] continuously.
   - Grant order is 2, 0, 2, 0…
   - Requester 1 re-requesting is served only after 2 and 0.
4. **Zero bypass:** req[3] with (0,15) gives `rsp_gcd`=15 with `done`[3] at T0+1, and `eng_start` is never asserted.
   - (0,0) gives `rsp_gcd`=0.
5. **CEN stall:** with (48,18) and `CEN` toggling at 1/4 duty:
   - Result is still 6; `eng_start` and `eng_ack` are each one cycle wide.
   - The arbiter stays in WAIT throughout the stall.
6. **Reset mid-WAIT:** assert `Reset` for one cycle during a job.
   - All outputs are 0 the next cycle and no `done` pulse is issued.
   - A subsequent req[2] with (9,6) is granted and returns 3.
